// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle control sequencer.
// State encodings, instruction classes, opcode/func constants and
// PC source codes used by mc_class_dec and mc_sequencer.
package mc_pkg;

  // Sequencer states; the numeric values are visible on the debug port.
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  // Instruction classes. NOP only exists as the reset value of the class register.
  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_IALU    = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BEQ     = 4'd4,
    CLS_BNE     = 4'd5,
    CLS_J       = 4'd6,
    CLS_JAL     = 4'd7,
    CLS_JR      = 4'd8,
    CLS_ILLEGAL = 4'd9,
    CLS_NOP     = 4'd10
  } cls_e;

  // Opcode field values (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function field value (IR[5:0]) that turns an R-type into jr.
  localparam logic [5:0] FUNC_JR  = 6'h08;

  // PC source select codes.
  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_RS  = 2'b11;

  // Immediate ALU ops occupy opcodes 0x08..0x0F, i.e. the 001xxx block.
  function automatic logic is_ialu(input logic [5:0] op);
    return (op[5:3] == 3'b001);
  endfunction

endpackage

// File: rtl/mc_class_dec.sv
// mc_class_dec: purely combinational op/func -> instruction class decoder.
// Anything not recognised is reported as CLS_ILLEGAL.
module mc_class_dec
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output cls_e       cls_o
);

  // Map the IR opcode (and func for op=0) onto an instruction class.
  always_comb begin
    cls_o = CLS_ILLEGAL;
    if (op_i == OP_RTYPE) begin
      cls_o = (func_i == FUNC_JR) ? CLS_JR : CLS_R;
    end else if (is_ialu(op_i)) begin
      cls_o = CLS_IALU;
    end else begin
      case (op_i)
        OP_LW:   cls_o = CLS_LOAD;
        OP_SW:   cls_o = CLS_STORE;
        OP_BEQ:  cls_o = CLS_BEQ;
        OP_BNE:  cls_o = CLS_BNE;
        OP_J:    cls_o = CLS_J;
        OP_JAL:  cls_o = CLS_JAL;
        default: cls_o = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle IF/ID/EXE/MEM/WB control for the MIPS core.
// Owns the timing of every architectural write (IR, PC, register file,
// memory) and counts retired instructions.
//
// Build option: ILLEGAL_TRAP_EN. When defined, an illegal opcode traps into
// HALT (halt=1, all enables 0 until rst). When undefined, an illegal opcode
// retires as a 2-cycle NOP and halt is constant 0.
//
// Memory handshake: the sequencer raises mem_rd (or mem_wr) together with
// iord and holds them unchanged every cycle until the memory answers with
// mem_rdy=1; the access completes in the cycle where both request and
// mem_rdy are high. mem_rdy outside IF/MEM is ignored.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_rdy,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_wr,
  output logic             mem_to_reg,
  output logic             link,
  output logic             instr_done,
  output logic             halt,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  cls_e             dec_cls;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The IR is valid from ID onwards; the class is captured at the end of ID.
  mc_class_dec u_class_dec (
    .op_i   (op),
    .func_i (func),
    .cls_o  (dec_cls)
  );

  // State register, captured class and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      cls_q   <= CLS_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, class capture and counter update.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IF: begin
        if (mem_rdy) state_d = S_ID;
      end
      S_ID: begin
        cls_d = dec_cls;
        case (dec_cls)
          CLS_J, CLS_JAL: state_d = S_IF;
          CLS_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d = S_IF;
`endif
          end
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        case (cls_q)
          CLS_R, CLS_IALU:       state_d = S_WB;
          CLS_LOAD, CLS_STORE:   state_d = S_MEM;
          default:               state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (mem_rdy) state_d = (cls_q == CLS_LOAD) ? S_WB : S_IF;
      end
      S_WB: state_d = S_IF;
      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_HALT;
`else
        state_d = S_IF;
`endif
      end
      default: state_d = S_IF;
    endcase
    // The counter advances on the same edge that ends the retiring cycle.
    if (instr_done) cnt_d = cnt_q + CNT_W'(1);
  end

  // Output decode from state/class/zero (plus mem_rdy in IF/MEM); all quiet in reset.
  always_comb begin
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = PCSRC_PC4;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    mem_to_reg = 1'b0;
    link       = 1'b0;
    instr_done = 1'b0;
    halt       = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          mem_rd = 1'b1;
          iord   = 1'b0;
          if (mem_rdy) begin
            ir_wr  = 1'b1;
            pc_wr  = 1'b1;
            pc_src = PCSRC_PC4;
          end
        end
        S_ID: begin
          case (dec_cls)
            CLS_J: begin
              pc_wr      = 1'b1;
              pc_src     = PCSRC_JMP;
              instr_done = 1'b1;
            end
            CLS_JAL: begin
              pc_wr      = 1'b1;
              pc_src     = PCSRC_JMP;
              reg_wr     = 1'b1;
              link       = 1'b1;
              instr_done = 1'b1;
            end
            CLS_ILLEGAL: begin
`ifndef ILLEGAL_TRAP_EN
              // PC already advanced in IF, so retiring here is a plain NOP.
              instr_done = 1'b1;
`endif
            end
            default: ;
          endcase
        end
        S_EXE: begin
          case (cls_q)
            CLS_BEQ: begin
              pc_wr      = zero;
              pc_src     = PCSRC_BR;
              instr_done = 1'b1;
            end
            CLS_BNE: begin
              pc_wr      = !zero;
              pc_src     = PCSRC_BR;
              instr_done = 1'b1;
            end
            CLS_JR: begin
              pc_wr      = 1'b1;
              pc_src     = PCSRC_RS;
              instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          iord = 1'b1;
          if (cls_q == CLS_LOAD) mem_rd = 1'b1;
          if (cls_q == CLS_STORE) begin
            mem_wr     = 1'b1;
            instr_done = mem_rdy;
          end
        end
        S_WB: begin
          reg_wr     = 1'b1;
          mem_to_reg = (cls_q == CLS_LOAD);
          instr_done = 1'b1;
        end
        S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
          halt = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed per-cycle vectors for mc_sequencer. Each driven
// cycle pushes its hand-computed expected outputs; a negedge monitor pops and
// compares. A second instance with a 4-bit counter exercises the wrap.
module tb_mc_sequencer;

  localparam int CW = 32;
  localparam int SW = 4;
  localparam int VW = 3 + 12 + CW + 3 + 12 + SW;

  // Enable vector bit weights: {ir_wr,pc_wr,pc_src[1:0],iord,mem_rd,mem_wr,
  // reg_wr,mem_to_reg,link,instr_done,halt}
  localparam logic [11:0] IR_WR  = 12'h800;
  localparam logic [11:0] PC_WR  = 12'h400;
  localparam logic [11:0] SRC_BR = 12'h100;
  localparam logic [11:0] SRC_J  = 12'h200;
  localparam logic [11:0] SRC_RS = 12'h300;
  localparam logic [11:0] IORD   = 12'h080;
  localparam logic [11:0] MRD    = 12'h040;
  localparam logic [11:0] MWR    = 12'h020;
  localparam logic [11:0] RWR    = 12'h010;
  localparam logic [11:0] M2R    = 12'h008;
  localparam logic [11:0] LNK    = 12'h004;
  localparam logic [11:0] DONE   = 12'h002;
  localparam logic [11:0] HLT    = 12'h001;
  localparam logic [11:0] FETCH  = IR_WR | PC_WR | MRD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op = 6'h00;
  logic [5:0] func = 6'h00;
  logic zero = 1'b0;
  logic mem_rdy = 1'b0;

  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic a_ir_wr, a_pc_wr, a_iord, a_mem_rd, a_mem_wr, a_reg_wr, a_mem_to_reg, a_link, a_done, a_halt;
  logic [1:0] a_pc_src;
  logic [2:0] a_state;
  logic [CW-1:0] a_cnt;
  logic b_ir_wr, b_pc_wr, b_iord, b_mem_rd, b_mem_wr, b_reg_wr, b_mem_to_reg, b_link, b_done, b_halt;
  logic [1:0] b_pc_src;
  logic [2:0] b_state;
  logic [SW-1:0] b_cnt;

  mc_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_rdy(mem_rdy),
    .ir_wr(a_ir_wr), .pc_wr(a_pc_wr), .pc_src(a_pc_src), .iord(a_iord),
    .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .reg_wr(a_reg_wr), .mem_to_reg(a_mem_to_reg),
    .link(a_link), .instr_done(a_done), .halt(a_halt), .state(a_state), .instr_cnt(a_cnt)
  );

  mc_sequencer #(.CNT_W(SW)) dut_w (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_rdy(mem_rdy),
    .ir_wr(b_ir_wr), .pc_wr(b_pc_wr), .pc_src(b_pc_src), .iord(b_iord),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .reg_wr(b_reg_wr), .mem_to_reg(b_mem_to_reg),
    .link(b_link), .instr_done(b_done), .halt(b_halt), .state(b_state), .instr_cnt(b_cnt)
  );

  logic [11:0] a_en, b_en;
  assign a_en = {a_ir_wr, a_pc_wr, a_pc_src, a_iord, a_mem_rd, a_mem_wr,
                 a_reg_wr, a_mem_to_reg, a_link, a_done, a_halt};
  assign b_en = {b_ir_wr, b_pc_wr, b_pc_src, b_iord, b_mem_rd, b_mem_wr,
                 b_reg_wr, b_mem_to_reg, b_link, b_done, b_halt};

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] exp_cnt = '0;

  logic [VW-1:0] mon_exp, mon_act;
  string         mon_nm;

  // Monitor: one expected vector per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_act = {a_state, a_en, a_cnt, b_state, b_en, b_cnt};
      checks++;
      if (mon_act !== mon_exp) begin
        failures++;
        $display("FAIL %s: actual=%h required=%h (state/en/cnt/state_w/en_w/cnt_w)",
                 mon_nm, mon_act, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one cycle and queue the outputs it must show; the counter model
  // tracks the pre-edge count shown during the cycle.
  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic rdy, input logic [2:0] st,
                     input logic [11:0] en, input string nm);
    logic [SW-1:0] small_cnt;
    @(posedge clk);
    #1;
    rst = r; op = o; func = f; zero = z; mem_rdy = rdy;
    small_cnt = exp_cnt[SW-1:0];
    exp_q.push_back({st, en, exp_cnt, st, en, small_cnt});
    name_q.push_back(nm);
    if (r) exp_cnt = '0;
    else if (en[1]) exp_cnt = exp_cnt + 1;
  endtask

  task automatic fetch(input logic [5:0] o, input logic [5:0] f, input string nm);
    cyc(1'b0, o, f, 1'b0, 1'b1, 3'd0, FETCH, {nm, "_if"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    cyc(1, 6'h00, 6'h00, 0, 1, 3'd0, 12'h000, "reset_state");

    // add: IF ID EXE WB, reg_wr only in WB
    fetch(6'h00, 6'h20, "add");
    cyc(0, 6'h00, 6'h20, 0, 1, 3'd1, 12'h000, "add_id");
    cyc(0, 6'h00, 6'h20, 0, 1, 3'd2, 12'h000, "add_exe");
    cyc(0, 6'h00, 6'h20, 0, 1, 3'd4, RWR | DONE, "add_wb");

    // lw with two stall cycles in MEM
    fetch(6'h23, 6'h00, "lw");
    cyc(0, 6'h23, 6'h00, 0, 1, 3'd1, 12'h000, "lw_id");
    cyc(0, 6'h23, 6'h00, 0, 1, 3'd2, 12'h000, "lw_exe");
    cyc(0, 6'h23, 6'h00, 0, 0, 3'd3, IORD | MRD, "lw_mem_stall1");
    cyc(0, 6'h23, 6'h00, 0, 0, 3'd3, IORD | MRD, "lw_mem_stall2");
    cyc(0, 6'h23, 6'h00, 0, 1, 3'd3, IORD | MRD, "lw_mem_rdy");
    cyc(0, 6'h23, 6'h00, 0, 1, 3'd4, RWR | M2R | DONE, "lw_wb");

    // beq taken, then not taken
    fetch(6'h04, 6'h00, "beq_t");
    cyc(0, 6'h04, 6'h00, 1, 1, 3'd1, 12'h000, "beq_t_id");
    cyc(0, 6'h04, 6'h00, 1, 1, 3'd2, PC_WR | SRC_BR | DONE, "beq_t_exe");
    fetch(6'h04, 6'h00, "beq_nt");
    cyc(0, 6'h04, 6'h00, 0, 1, 3'd1, 12'h000, "beq_nt_id");
    cyc(0, 6'h04, 6'h00, 0, 1, 3'd2, SRC_BR | DONE, "beq_nt_exe");

    // bne taken (zero=0), then not taken (zero=1)
    fetch(6'h05, 6'h00, "bne_t");
    cyc(0, 6'h05, 6'h00, 0, 1, 3'd1, 12'h000, "bne_t_id");
    cyc(0, 6'h05, 6'h00, 0, 1, 3'd2, PC_WR | SRC_BR | DONE, "bne_t_exe");
    fetch(6'h05, 6'h00, "bne_nt");
    cyc(0, 6'h05, 6'h00, 1, 1, 3'd1, 12'h000, "bne_nt_id");
    cyc(0, 6'h05, 6'h00, 1, 1, 3'd2, SRC_BR | DONE, "bne_nt_exe");

    // jal and j retire in ID
    fetch(6'h03, 6'h00, "jal");
    cyc(0, 6'h03, 6'h00, 0, 1, 3'd1, PC_WR | SRC_J | RWR | LNK | DONE, "jal_id");
    fetch(6'h02, 6'h00, "j");
    cyc(0, 6'h02, 6'h00, 0, 1, 3'd1, PC_WR | SRC_J | DONE, "j_id");

    // jr
    fetch(6'h00, 6'h08, "jr");
    cyc(0, 6'h00, 6'h08, 0, 1, 3'd1, 12'h000, "jr_id");
    cyc(0, 6'h00, 6'h08, 0, 1, 3'd2, PC_WR | SRC_RS | DONE, "jr_exe");

    // immediate ALU range edges 0x08 and 0x0F
    fetch(6'h08, 6'h00, "addi");
    cyc(0, 6'h08, 6'h00, 0, 1, 3'd1, 12'h000, "addi_id");
    cyc(0, 6'h08, 6'h00, 0, 1, 3'd2, 12'h000, "addi_exe");
    cyc(0, 6'h08, 6'h00, 0, 1, 3'd4, RWR | DONE, "addi_wb");
    fetch(6'h0F, 6'h00, "lui");
    cyc(0, 6'h0F, 6'h00, 0, 1, 3'd1, 12'h000, "lui_id");
    cyc(0, 6'h0F, 6'h00, 0, 1, 3'd2, 12'h000, "lui_exe");
    cyc(0, 6'h0F, 6'h00, 0, 1, 3'd4, RWR | DONE, "lui_wb");

    // sw with a fetch stall, mem_rdy already high on MEM entry
    cyc(0, 6'h2B, 6'h00, 0, 0, 3'd0, MRD, "sw_if_stall");
    fetch(6'h2B, 6'h00, "sw");
    cyc(0, 6'h2B, 6'h00, 0, 1, 3'd1, 12'h000, "sw_id");
    cyc(0, 6'h2B, 6'h00, 0, 1, 3'd2, 12'h000, "sw_exe");
    cyc(0, 6'h2B, 6'h00, 0, 1, 3'd3, IORD | MWR | DONE, "sw_mem");

    // mem_rdy low outside IF/MEM must not stall
    fetch(6'h00, 6'h20, "add2");
    cyc(0, 6'h00, 6'h20, 0, 0, 3'd1, 12'h000, "add2_id");
    cyc(0, 6'h00, 6'h20, 0, 0, 3'd2, 12'h000, "add2_exe");
    cyc(0, 6'h00, 6'h20, 0, 0, 3'd4, RWR | DONE, "add2_wb");

    // a run of jumps carries the 4-bit counter through its wrap
    for (int i = 0; i < 6; i++) begin
      fetch(6'h02, 6'h00, "jrun");
      cyc(0, 6'h02, 6'h00, 0, 1, 3'd1, PC_WR | SRC_J | DONE, "jrun_id");
    end

`ifdef ILLEGAL_TRAP_EN
    fetch(6'h3F, 6'h00, "ill3f");
    cyc(0, 6'h3F, 6'h00, 0, 1, 3'd1, 12'h000, "ill3f_id");
    for (int i = 0; i < 10; i++) begin
      cyc(0, 6'h3F, 6'h00, i[0], 1, 3'd5, HLT, "halt_hold");
    end
    cyc(1, 6'h3F, 6'h00, 0, 1, 3'd5, 12'h000, "halt_rst");
`else
    fetch(6'h3F, 6'h00, "ill3f");
    cyc(0, 6'h3F, 6'h00, 0, 1, 3'd1, DONE, "ill3f_id");
    fetch(6'h07, 6'h00, "ill07");
    cyc(0, 6'h07, 6'h00, 0, 1, 3'd1, DONE, "ill07_id");
    fetch(6'h10, 6'h00, "ill10");
    cyc(0, 6'h10, 6'h00, 0, 1, 3'd1, DONE, "ill10_id");
`endif

    // sw stalled in MEM, reset drops the request and clears the count
    fetch(6'h2B, 6'h00, "sw_r");
    cyc(0, 6'h2B, 6'h00, 0, 1, 3'd1, 12'h000, "sw_r_id");
    cyc(0, 6'h2B, 6'h00, 0, 1, 3'd2, 12'h000, "sw_r_exe");
    cyc(0, 6'h2B, 6'h00, 0, 0, 3'd3, IORD | MWR, "sw_r_stall");
    cyc(1, 6'h2B, 6'h00, 0, 0, 3'd3, 12'h000, "sw_r_rst_cycle");
    fetch(6'h00, 6'h20, "post_rst_add");
    cyc(0, 6'h00, 6'h20, 0, 1, 3'd1, 12'h000, "post_rst_add_id");
    cyc(0, 6'h00, 6'h20, 0, 1, 3'd2, 12'h000, "post_rst_add_exe");
    cyc(0, 6'h00, 6'h20, 0, 1, 3'd4, RWR | DONE, "post_rst_add_wb");
    fetch(6'h02, 6'h00, "final");

    // let the monitor drain, then confirm nothing was left unchecked
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
